mux_rr_n_1: RTL and testbench

Parametrised N-to-1 datapath multiplexer with registered output, valid/ready handshake and built-in arbitration. It replaces fixed 2:1 32-bit select muxes wherever several producers share one consumer, e.g. writeback source selection or memory-port sharing between fetch and load/store. Selection comes from an internal round-robin or fixed-priority arbiter, not an external select. The selected word is registered, so the block also acts as a one-deep pipeline buffer.

---
 rtl/mux_rr_n_1.sv | 77 +++++++
 tb/tb_mux_rr_n_1.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_n_1.sv
// N-to-1 multiplexer with registered output, valid/ready handshake and
// built-in round-robin (MODE=0) or fixed-priority (MODE=1) arbitration.
module mux_rr_n_1 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned MODE  = 0,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_sel,
  input  logic                 out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  grant;
  logic              found;
  logic              load_en;
  int unsigned       idx;

  assign out_valid = (state_q == FULL);
  assign load_en   = rst_n && (!out_valid || out_ready);

  // Circular search from ptr; ptr stays 0 in fixed-priority mode, so the
  // same loop yields lowest-index-wins there.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        grant = SEL_W'(idx);
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (load_en && found) in_ready[grant] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    if (load_en) begin
      if (found)          state_d = FULL;
      else if (out_ready) state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      out_data <= '0;
      out_sel  <= '0;
      ptr      <= '0;
    end else begin
      state_q <= state_d;
      if (load_en && found) begin
        out_data <= in_data[grant*WIDTH +: WIDTH];
        out_sel  <= grant;
        if (MODE == 0) ptr <= (grant == SEL_W'(N-1)) ? '0 : grant + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_n_1.sv
// Self-checking bench for mux_rr_n_1: directed scenarios plus randomized
// traffic against a behavioural model on three configurations.
module tb_mux_rr_n_1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [3:0]   iv   [3];
  logic [127:0] id   [3];
  logic         ordy [3];

  wire [3:0]  ir0, ir1;
  wire [2:0]  ir2;
  wire        ov0, ov1, ov2;
  wire [31:0] od0, od1, od2;
  wire [1:0]  os0, os1, os2;

  logic [3:0]  ir [3];
  logic        ov [3];
  logic [31:0] od [3];
  logic [1:0]  os [3];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state per instance (0: RR N=4, 1: priority N=4, 2: RR N=3)
  int          m_ptr [3];
  logic        m_v   [3];
  logic [31:0] m_d   [3];
  int          m_s   [3];

  always #5 clk = ~clk;

  mux_rr_n_1 #(.WIDTH(32), .N(4), .MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_data(id[0]), .in_ready(ir0),
    .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(ordy[0]));

  mux_rr_n_1 #(.WIDTH(32), .N(4), .MODE(1)) u_fp (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_data(id[1]), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(ordy[1]));

  mux_rr_n_1 #(.WIDTH(32), .N(3), .MODE(0)) u_n3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2][2:0]), .in_data(id[2][95:0]), .in_ready(ir2),
    .out_valid(ov2), .out_data(od2), .out_sel(os2), .out_ready(ordy[2]));

  always_comb begin
    ir[0] = ir0; ir[1] = ir1; ir[2] = {1'b0, ir2};
    ov[0] = ov0; ov[1] = ov1; ov[2] = ov2;
    od[0] = od0; od[1] = od1; od[2] = od2;
    os[0] = os0; os[1] = os1; os[2] = os2;
  end

  // Grant the spec's rules would give this cycle, or -1 if none.
  function automatic int pick(input int w);
    int n, p, c;
    n = (w == 2) ? 3 : 4;
    p = (w == 1) ? 0 : m_ptr[w];
    if (m_v[w] && !ordy[w]) return -1;
    for (int k = 0; k < n; k++) begin
      c = (p + k) % n;
      if (iv[w][c]) return c;
    end
    return -1;
  endfunction

  task automatic model_edge(input int w);
    int g, n;
    n = (w == 2) ? 3 : 4;
    g = pick(w);
    if (g >= 0) begin
      m_d[w] = id[w][g*32 +: 32];
      m_s[w] = g;
      m_v[w] = 1'b1;
      if (w != 1) m_ptr[w] = (g + 1) % n;
    end else if (ordy[w]) begin
      m_v[w] = 1'b0;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    for (int w = 0; w < 3; w++) begin
      iv[w] = '0;
      ordy[w] = 1'b0;
    end
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    apply_reset();
    id[0][31:0]  = 32'hC0C0C0C0;
    id[0][95:64] = 32'hA5A5A5A5;
    iv[0] = 4'b0100;
    tick();
    n_checks++;
    if (od[0] !== 32'hA5A5A5A5 || ov[0] !== 1'b1) begin
      n_fail++; $display("FAIL reset_prefill: got v=%0b d=%h expected v=1 d=a5a5a5a5", ov[0], od[0]);
    end
    iv[0] = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", ov[0]); end
    n_checks++;
    if (od[0] !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", od[0]); end
    n_checks++;
    if (os[0] !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got %0d expected 0", os[0]); end
    n_checks++;
    if (ir[0] !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", ir[0]); end
    #1 rst_n = 1'b1;
    #1;
    n_checks++;
    if (ir[0] !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b expected 0001", ir[0]); end
    tick();
    n_checks++;
    if (ov[0] !== 1'b1 || os[0] !== 2'd0 || od[0] !== 32'hC0C0C0C0) begin
      n_fail++; $display("FAIL reset_first_word: got v=%0b s=%0d d=%h expected v=1 s=0 d=c0c0c0c0", ov[0], os[0], od[0]);
    end
  endtask

  task automatic test_single;
    iv[0] = 4'b0000;
    ordy[0] = 1'b1;
    tick();
    n_checks++;
    if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %0b expected 0", ov[0]); end
    id[0][95:64] = 32'hDEADBEEF;
    iv[0] = 4'b0100;
    #1;
    n_checks++;
    if (ir[0] !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b expected 0100", ir[0]); end
    tick();
    n_checks++;
    if (ov[0] !== 1'b1 || od[0] !== 32'hDEADBEEF || os[0] !== 2'd2) begin
      n_fail++; $display("FAIL single_out: got v=%0b s=%0d d=%h expected v=1 s=2 d=deadbeef", ov[0], os[0], od[0]);
    end
    iv[0] = 4'b0000;
    #1;
    n_checks++;
    if (ir[0] !== 4'b0000) begin n_fail++; $display("FAIL single_ready_drop: got %b expected 0000", ir[0]); end
  endtask

  task automatic test_rr_rotation;
    apply_reset();
    id[0] = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    iv[0] = 4'b1111;
    ordy[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (ov[0] !== 1'b1 || os[0] !== 2'(i % 4) || od[0] !== {4{8'(8'h11 * (i % 4))}}) begin
        n_fail++; $display("FAIL rr_rotation[%0d]: got v=%0b s=%0d d=%h expected v=1 s=%0d", i, ov[0], os[0], od[0], i % 4);
      end
    end
  endtask

  task automatic test_backpressure;
    apply_reset();
    id[0] = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    iv[0] = 4'b0010;
    tick();
    n_checks++;
    if (os[0] !== 2'd1 || od[0] !== 32'h11111111) begin
      n_fail++; $display("FAIL bp_fill: got s=%0d d=%h expected s=1 d=11111111", os[0], od[0]);
    end
    iv[0] = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (ir[0] !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 0000", i, ir[0]); end
      tick();
      n_checks++;
      if (ov[0] !== 1'b1 || os[0] !== 2'd1 || od[0] !== 32'h11111111) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%0b s=%0d d=%h expected v=1 s=1 d=11111111", i, ov[0], os[0], od[0]);
      end
    end
    ordy[0] = 1'b1;
    #1;
    n_checks++;
    if (ir[0] !== 4'b0100) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 0100", ir[0]); end
    tick();
    n_checks++;
    if (ov[0] !== 1'b1 || os[0] !== 2'd2 || od[0] !== 32'h22222222) begin
      n_fail++; $display("FAIL bp_reload: got v=%0b s=%0d d=%h expected v=1 s=2 d=22222222", ov[0], os[0], od[0]);
    end
  endtask

  task automatic test_fixed_priority;
    apply_reset();
    id[1] = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    iv[1] = 4'b1010;
    ordy[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (ir[1] !== 4'b0010) begin n_fail++; $display("FAIL fp_ready[%0d]: got %b expected 0010", i, ir[1]); end
      tick();
      n_checks++;
      if (ov[1] !== 1'b1 || os[1] !== 2'd1) begin
        n_fail++; $display("FAIL fp_sel[%0d]: got v=%0b s=%0d expected v=1 s=1", i, ov[1], os[1]);
      end
    end
    iv[1] = 4'b1000;
    #1;
    n_checks++;
    if (ir[1] !== 4'b1000) begin n_fail++; $display("FAIL fp_ch3_ready: got %b expected 1000", ir[1]); end
    tick();
    n_checks++;
    if (os[1] !== 2'd3 || od[1] !== 32'h33333333) begin
      n_fail++; $display("FAIL fp_ch3_sel: got s=%0d d=%h expected s=3 d=33333333", os[1], od[1]);
    end
  endtask

  task automatic test_wrap;
    logic [3:0] exp_ir;
    apply_reset();
    id[2] = {32'hFFFFFFFF, 32'h22222222, 32'h11111111, 32'h00000000};
    iv[2] = 4'b1111;
    ordy[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_ir = 4'b0001 << (i % 3);
      #1;
      n_checks++;
      if (ir[2] !== exp_ir) begin n_fail++; $display("FAIL wrap_ready[%0d]: got %b expected %b", i, ir[2], exp_ir); end
      tick();
      n_checks++;
      if (ov[2] !== 1'b1 || os[2] !== 2'(i % 3)) begin
        n_fail++; $display("FAIL wrap_sel[%0d]: got v=%0b s=%0d expected v=1 s=%0d", i, ov[2], os[2], i % 3);
      end
      n_checks++;
      if (u_n3.ptr === 2'd3) begin n_fail++; $display("FAIL wrap_ptr[%0d]: got 3 expected below 3", i); end
    end
  endtask

  task automatic test_random(input int w, input int cycles);
    int g, last_g;
    logic [3:0] exp_ir;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      m_ptr[k] = 0; m_v[k] = 1'b0; m_d[k] = '0; m_s[k] = 0;
    end
    last_g = -1;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      for (int c = 0; c < 4; c++) begin
        if (iv[w][c] && c != last_g) begin
          iv[w][c] = ($urandom_range(0, 3) != 0);
        end else begin
          iv[w][c] = 1'($urandom_range(0, 1));
          id[w][c*32 +: 32] = $urandom;
        end
      end
      ordy[w] = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      g = pick(w);
      exp_ir = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      n_checks++;
      if (ir[w] !== exp_ir) begin n_fail++; $display("FAIL rand%0d_ready[%0d]: got %b expected %b", w, cyc, ir[w], exp_ir); end
      n_checks++;
      if (ov[w] !== m_v[w]) begin n_fail++; $display("FAIL rand%0d_valid[%0d]: got %0b expected %0b", w, cyc, ov[w], m_v[w]); end
      n_checks++;
      if (od[w] !== m_d[w] || os[w] !== 2'(m_s[w])) begin
        n_fail++; $display("FAIL rand%0d_out[%0d]: got s=%0d d=%h expected s=%0d d=%h", w, cyc, os[w], od[w], m_s[w], m_d[w]);
      end
      @(posedge clk);
      model_edge(w);
      last_g = g;
      #1;
    end
  endtask

  initial begin
    for (int w = 0; w < 3; w++) begin
      iv[w] = '0; id[w] = '0; ordy[w] = 1'b0;
    end
    test_reset();
    test_single();
    test_rr_rotation();
    test_backpressure();
    test_fixed_priority();
    test_wrap();
    test_random(0, 300);
    test_random(1, 300);
    test_random(2, 300);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
